// File: rtl/xcr_ecp_seq_pkg.sv
// ---------------------------------------------------------------------------
// xcr_ecp_seq_pkg
// Shared definitions for the exception/interrupt entry sequencer:
//   - state_t   : sequencer FSM states
//   - ADR_*     : CR register addresses on the controller bus
//   - INTEN_*   : values written to the global interrupt-enable register
//   - VEC_SHIFT : vector table stride (one 4-byte entry per cause code)
//   - vec_target: vector table entry address for a cause code
// ---------------------------------------------------------------------------
package xcr_ecp_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_XCP  = 4'd1,
    ST_RD_INT  = 4'd2,
    ST_CLR     = 4'd3,
    ST_DIS     = 4'd4,
    ST_JUMP    = 4'd5,
    ST_HANDLER = 4'd6,
    ST_RET_EN  = 4'd7,
    ST_RET_JMP = 4'd8
  } state_t;

  localparam logic [2:0] ADR_INTC = 3'd0;
  localparam logic [2:0] ADR_XCPP = 3'd5;
  localparam logic [2:0] ADR_INTP = 3'd6;

  localparam logic [7:0] INTEN_SET = 8'h80;
  localparam logic [7:0] INTEN_CLR = 8'h00;

  localparam int VEC_SHIFT = 2;

  // Vector entry = base + cause * 4; the 24-bit sum wraps with no carry out.
  function automatic logic [23:0] vec_target(input logic [23:0] base,
                                             input logic [3:0]  cause);
    logic [23:0] w_ofs;
    w_ofs = {20'd0, cause} << VEC_SHIFT;
    return base + w_ofs;
  endfunction

endpackage

// File: rtl/xcr_prio_enc8.sv
// ---------------------------------------------------------------------------
// xcr_prio_enc8
// 8-to-3 priority encoder selecting the LOWEST set bit (bit 0 wins).
// Ports:
//   i_vec   in  8  pending bits
//   o_valid out 1  at least one bit of i_vec is set
//   o_idx   out 3  index of the lowest set bit (0 when o_valid=0)
// ---------------------------------------------------------------------------
module xcr_prio_enc8 (
  input  logic [7:0] i_vec,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  always_comb begin
    o_valid = |i_vec;
    o_idx   = 3'd0;
    // Scan from the top so the last hit, i.e. the lowest bit, is kept.
    for (int i = 7; i >= 0; i--) begin
      if (i_vec[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/xcr_ecp_seq.sv
// ---------------------------------------------------------------------------
// xcr_ecp_seq
// Exception/interrupt entry and return sequencer. On an accepted request it
// reads the exception-pending then interrupt-pending CR registers, clears the
// winning pending bit (w1c), disables global interrupts, redirects the CPU to
// the vector entry, and on return re-enables interrupts and jumps back to epc.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   int_req      in  1  controller INT output
//   ivec_addr    in  24 vector table base
//   instr_bound  in  1  CPU at an instruction boundary
//   cur_pc       in  24 PC of next instruction
//   ret_req      in  1  return-from-interrupt pulse (honoured in HANDLER only)
//   cpu_stall    out 1  pipeline hold, RD_XCP..JUMP
//   redirect     out 1  1-cycle PC redirect strobe
//   redirect_pc  out 24 redirect target, 0 when redirect=0
//   in_handler   out 1  HANDLER, RET_EN, RET_JMP
//   cause        out 4  {is_exception, bit index}
//   epc          out 24 saved return PC
//   cr_cs/we/adr/wdata  CR bus initiator outputs, all 0 when idle
//   cr_rdata     in  8  combinational read data
//   dbg_state    out 4  current FSM state
//
// CR bus: each cycle is one clock with cr_cs=1 for that clock only; read data
// is combinational from cr_adr and is sampled at the edge closing the cycle.
// There is no wait state or ready; the target must accept every cycle.
// ---------------------------------------------------------------------------
module xcr_ecp_seq
  import xcr_ecp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [23:0] ivec_addr,
  input  logic        instr_bound,
  input  logic [23:0] cur_pc,
  input  logic        ret_req,
  output logic        cpu_stall,
  output logic        redirect,
  output logic [23:0] redirect_pc,
  output logic        in_handler,
  output logic [3:0]  cause,
  output logic [23:0] epc,
  output logic        cr_cs,
  output logic        cr_we,
  output logic [2:0]  cr_adr,
  output logic [7:0]  cr_wdata,
  input  logic [7:0]  cr_rdata,
  output state_t      dbg_state
);

  state_t      r_state;
  logic [3:0]  r_cause;
  logic [23:0] r_epc;
  logic [2:0]  r_clr_adr;
  logic [7:0]  r_clr_mask;

  logic        w_pend_valid;
  logic [2:0]  w_pend_idx;

  // One encoder serves both pending-register reads; only one is on the bus.
  xcr_prio_enc8 u_prio (
    .i_vec   (cr_rdata),
    .o_valid (w_pend_valid),
    .o_idx   (w_pend_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cause    <= 4'd0;
      r_epc      <= 24'd0;
      r_clr_adr  <= 3'd0;
      r_clr_mask <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (int_req && instr_bound) begin
            r_epc   <= cur_pc;
            r_state <= ST_RD_XCP;
          end
        end
        ST_RD_XCP: begin
          if (w_pend_valid) begin
            r_cause    <= {1'b1, w_pend_idx};
            r_clr_adr  <= ADR_XCPP;
            r_clr_mask <= 8'd1 << w_pend_idx;
            r_state    <= ST_CLR;
          end else begin
            r_state <= ST_RD_INT;
          end
        end
        ST_RD_INT: begin
          if (w_pend_valid) begin
            r_cause    <= {1'b0, w_pend_idx};
            r_clr_adr  <= ADR_INTP;
            r_clr_mask <= 8'd1 << w_pend_idx;
            r_state    <= ST_CLR;
          end else begin
            // Spurious request: nothing pending, cause left untouched.
            r_state <= ST_IDLE;
          end
        end
        ST_CLR:     r_state <= ST_DIS;
        ST_DIS:     r_state <= ST_JUMP;
        ST_JUMP:    r_state <= ST_HANDLER;
        ST_HANDLER: begin
          // int_req is deliberately not looked at here: no nesting.
          if (ret_req) r_state <= ST_RET_EN;
        end
        ST_RET_EN:  r_state <= ST_RET_JMP;
        ST_RET_JMP: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state alone, so a reset that returns the
  // FSM to IDLE silences the bus and the redirect on the following cycle.
  always_comb begin
    cpu_stall   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 24'd0;
    in_handler  = 1'b0;
    cr_cs       = 1'b0;
    cr_we       = 1'b0;
    cr_adr      = 3'd0;
    cr_wdata    = 8'd0;
    case (r_state)
      ST_RD_XCP: begin
        cpu_stall = 1'b1;
        cr_cs     = 1'b1;
        cr_adr    = ADR_XCPP;
      end
      ST_RD_INT: begin
        cpu_stall = 1'b1;
        cr_cs     = 1'b1;
        cr_adr    = ADR_INTP;
      end
      ST_CLR: begin
        cpu_stall = 1'b1;
        cr_cs     = 1'b1;
        cr_we     = 1'b1;
        cr_adr    = r_clr_adr;
        cr_wdata  = r_clr_mask;
      end
      ST_DIS: begin
        cpu_stall = 1'b1;
        cr_cs     = 1'b1;
        cr_we     = 1'b1;
        cr_adr    = ADR_INTC;
        cr_wdata  = INTEN_CLR;
      end
      ST_JUMP: begin
        cpu_stall   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = vec_target(ivec_addr, r_cause);
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
      end
      ST_RET_EN: begin
        in_handler = 1'b1;
        cr_cs      = 1'b1;
        cr_we      = 1'b1;
        cr_adr     = ADR_INTC;
        cr_wdata   = INTEN_SET;
      end
      ST_RET_JMP: begin
        in_handler  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = r_epc;
      end
      default: ;
    endcase
  end

  assign cause     = r_cause;
  assign epc       = r_epc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_xcr_ecp_seq.sv
// ---------------------------------------------------------------------------
// tb_xcr_ecp_seq
// Bench for xcr_ecp_seq. The bench plays the interrupt controller: it holds
// the pending/enable registers, answers reads combinationally and applies
// writes (w1c for pending registers). Expected bus traffic for each request
// is derived from the pending values and queued in exp_q.
// ---------------------------------------------------------------------------
module tb_xcr_ecp_seq;
  import xcr_ecp_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        int_req, instr_bound, ret_req;
  logic [23:0] ivec_addr, cur_pc;
  logic        cpu_stall, redirect, in_handler;
  logic [23:0] redirect_pc, epc;
  logic [3:0]  cause;
  logic        cr_cs, cr_we;
  logic [2:0]  cr_adr;
  logic [7:0]  cr_wdata, cr_rdata;
  state_t      dbg_state;

  xcr_ecp_seq dut (
    .clk         (clk),
    .rst         (rst),
    .int_req     (int_req),
    .ivec_addr   (ivec_addr),
    .instr_bound (instr_bound),
    .cur_pc      (cur_pc),
    .ret_req     (ret_req),
    .cpu_stall   (cpu_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_handler  (in_handler),
    .cause       (cause),
    .epc         (epc),
    .cr_cs       (cr_cs),
    .cr_we       (cr_we),
    .cr_adr      (cr_adr),
    .cr_wdata    (cr_wdata),
    .cr_rdata    (cr_rdata),
    .dbg_state   (dbg_state)
  );

  // ---------------- controller model ----------------
  logic [7:0] m_xcp, m_int, m_inten;

  always_comb begin
    cr_rdata = 8'h00;
    case (cr_adr)
      3'd0:    cr_rdata = m_inten;
      3'd5:    cr_rdata = m_xcp;
      3'd6:    cr_rdata = m_int;
      default: cr_rdata = 8'h00;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];        // {we, adr, wdata}
  int          n_chk;
  int          n_pass;
  int          bus_unexp;
  logic [23:0] last_rpc;
  logic [3:0]  exp_cause;
  logic [23:0] exp_epc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Advance to the next falling edge, then score bus activity and apply
  // any write to the controller model.
  task automatic tick();
    logic [11:0] op;
    logic [11:0] e;
    @(negedge clk);
    if (redirect) last_rpc = redirect_pc;
    if (cr_cs) begin
      op = {cr_we, cr_adr, cr_wdata};
      if (exp_q.size() == 0) begin
        bus_unexp++;
      end else begin
        e = exp_q.pop_front();
        chk("bus_op", 32'(op), 32'(e));
      end
      if (cr_we) begin
        case (cr_adr)
          3'd0:    m_inten = cr_wdata;
          3'd5:    m_xcp   = m_xcp & ~cr_wdata;
          3'd6:    m_int   = m_int & ~cr_wdata;
          default: ;
        endcase
      end
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  32'(cpu_stall),   0);
    chk({tag, "_redir"},  32'(redirect),    0);
    chk({tag, "_rpc"},    32'(redirect_pc), 0);
    chk({tag, "_inh"},    32'(in_handler),  0);
    chk({tag, "_cause"},  32'(cause),       0);
    chk({tag, "_epc"},    32'(epc),         0);
    chk({tag, "_cs"},     32'(cr_cs),       0);
    chk({tag, "_we"},     32'(cr_we),       0);
    chk({tag, "_adr"},    32'(cr_adr),      0);
    chk({tag, "_wdata"},  32'(cr_wdata),    0);
  endtask

  // ---------------- driver tasks ----------------
  // One request from the IDLE state. Called at a falling edge.
  task automatic run_req(input logic [7:0] xcp, input logic [7:0] intp,
                         input logic [23:0] ivec, input logic [23:0] pc,
                         input int wait_k);
    int          lat, nst, bit_i;
    logic        spur;
    logic [3:0]  ec;
    logic [23:0] exp_pc;
    m_xcp = xcp; m_int = intp; m_inten = 8'h80;
    ivec_addr = ivec; cur_pc = pc;
    int_req = 1'b1; instr_bound = 1'b0;
    for (int k = 0; k < wait_k; k++) begin
      tick();
      chk("no_accept_stall", 32'(cpu_stall), 0);
    end
    spur = 1'b0; lat = 0; ec = exp_cause;
    exp_q.push_back({1'b0, 3'd5, 8'h00});
    if (xcp != 0) begin
      bit_i = lowest(xcp);
      exp_q.push_back({1'b1, 3'd5, 8'(1 << bit_i)});
      ec = {1'b1, 3'(bit_i)}; lat = 4;
    end else begin
      exp_q.push_back({1'b0, 3'd6, 8'h00});
      if (intp != 0) begin
        bit_i = lowest(intp);
        exp_q.push_back({1'b1, 3'd6, 8'(1 << bit_i)});
        ec = {1'b0, 3'(bit_i)}; lat = 5;
      end else begin
        spur = 1'b1;
      end
    end
    if (!spur) exp_q.push_back({1'b1, 3'd0, 8'h00});
    nst = spur ? 2 : lat;
    exp_pc = 24'((int'(ivec) + int'(ec) * 4) % (1 << 24));
    exp_cause = ec;
    exp_epc = pc;
    instr_bound = 1'b1;
    for (int n = 1; n <= nst + 1; n++) begin
      tick();
      if (spur && n == 1) int_req = 1'b0;
      instr_bound = 1'($urandom_range(0, 1));
      chk("stall",    32'(cpu_stall),  32'(n <= nst));
      chk("redirect", 32'(redirect),   32'(!spur && n == lat));
      chk("in_hndlr", 32'(in_handler), 32'(!spur && n > lat));
      if (!spur && n == lat) chk("redir_pc", 32'(redirect_pc), 32'(exp_pc));
    end
    chk("cause",    32'(cause), 32'(exp_cause));
    chk("epc",      32'(epc),   32'(exp_epc));
    chk("bus_left", 32'(exp_q.size()), 0);
    chk("bus_unexp", 32'(bus_unexp), 0);
    if (!spur) begin
      // int_req still high: must not nest.
      for (int h = 0; h < int'($urandom_range(1, 4)); h++) begin
        tick();
        chk("hndlr_hold", 32'({in_handler, cpu_stall, redirect}), 32'(3'b100));
      end
      chk("inten_off", 32'(m_inten), 0);
    end
    int_req = 1'b0;
  endtask

  // Return from HANDLER. Called at a falling edge.
  task automatic do_ret();
    exp_q.push_back({1'b1, 3'd0, 8'h80});
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    chk("ret_en_inh",  32'({in_handler, redirect}), 32'(2'b10));
    tick();
    chk("ret_jmp",     32'({in_handler, redirect}), 32'(2'b11));
    chk("ret_pc",      32'(redirect_pc), 32'(exp_epc));
    tick();
    chk("ret_idle",    32'({in_handler, redirect, cr_cs}), 0);
    chk("ret_inten",   32'(m_inten), 32'h80);
    chk("ret_bus_left", 32'(exp_q.size()), 0);
    chk("ret_unexp",   32'(bus_unexp), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_chk = 0; n_pass = 0; bus_unexp = 0; last_rpc = 24'd0;
    exp_cause = 4'd0; exp_epc = 24'd0;
    rst = 1'b1; int_req = 1'b0; instr_bound = 1'b0; ret_req = 1'b0;
    ivec_addr = 24'd0; cur_pc = 24'd0;
    m_xcp = 8'h00; m_int = 8'h00; m_inten = 8'h80;
    tick(); tick();
    chk_all_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Interrupt path
    run_req(8'h00, 8'h24, 24'h001000, 24'h000456, 1);
    chk("dir_int_rpc",   32'(last_rpc), 32'h001008);
    chk("dir_int_cause", 32'(cause), 32'h2);
    chk("dir_int_epc",   32'(epc), 32'h000456);
    chk("dir_int_pend",  32'(m_int), 32'h20);
    do_ret();

    // ret_req in IDLE: ignored
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("idle_ret", 32'({cr_cs, redirect, in_handler}), 0);
      tick();
    end
    chk("idle_ret_unexp", 32'(bus_unexp), 0);

    // Exception priority
    run_req(8'h80, 8'h01, 24'h123400, 24'h00ABCD, 0);
    chk("dir_xcp_cause", 32'(cause), 32'hF);
    chk("dir_xcp_rpc",   32'(last_rpc), 32'h12343C);
    chk("dir_xcp_intp",  32'(m_int), 32'h01);
    do_ret();

    // Wrap-around
    run_req(8'h00, 8'h08, 24'hFFFFF8, 24'h000100, 2);
    chk("dir_wrap_rpc", 32'(last_rpc), 32'h000004);
    do_ret();

    // Spurious
    run_req(8'h00, 8'h00, 24'h002000, 24'h000200, 0);
    chk("dir_spur_cause", 32'(cause), 32'h3);
    tick();
    chk("spur_idle", 32'({cpu_stall, redirect, cr_cs}), 0);

    // Reset in DIS (interrupt path: RD_XCP, RD_INT, CLR, DIS)
    m_xcp = 8'h00; m_int = 8'h10; m_inten = 8'h80;
    ivec_addr = 24'h003000; cur_pc = 24'h000777;
    int_req = 1'b1; instr_bound = 1'b1;
    exp_q.push_back({1'b0, 3'd5, 8'h00});
    exp_q.push_back({1'b0, 3'd6, 8'h00});
    exp_q.push_back({1'b1, 3'd6, 8'h10});
    exp_q.push_back({1'b1, 3'd0, 8'h00});
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 1) int_req = 1'b0;
    end
    chk("dis_stall", 32'(cpu_stall), 1);
    rst = 1'b1;
    tick();
    chk_all_zero("rst_dis");
    rst = 1'b0;
    exp_cause = 4'd0; exp_epc = 24'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_quiet", 32'({redirect, cr_cs, cpu_stall}), 0);
    end
    chk("post_rst_left", 32'(exp_q.size()), 0);
    run_req(8'h00, 8'h30, 24'h004000, 24'h000888, 0);
    chk("post_rst_rpc", 32'(last_rpc), 32'h004010);
    do_ret();

    // Randomized requests
    for (int t = 0; t < 24; t++) begin
      logic [7:0] rx, ri;
      rx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      ri = ($urandom_range(0, 4) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_req(rx, ri, 24'($urandom), 24'($urandom), int'($urandom_range(0, 2)));
      if (rx != 0 || ri != 0) do_ret();
      else tick();
    end

    chk("final_unexp", 32'(bus_unexp), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
